// File: rtl/reset_pkg.sv
// Shared encodings for the reset sequencer: reset causes, FSM states and
// the release-point helper used by the channel release comparators.
package reset_pkg;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_SW  = 2'd1;
  localparam logic [1:0] CAUSE_WDT = 2'd2;

  localparam logic [1:0] ST_ASSERT  = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  // Counter value seen just before the edge that releases channel ch
  // (the counter reads 0 in the cycle after T0).
  function automatic int unsigned release_count(input int unsigned hold,
                                                input int unsigned stagger,
                                                input int unsigned ch);
    return hold - 1 + ch * stagger;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-release flop chain for any asynchronous active-low reset.
module reset_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic resetn,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) chain <= '0;
    else         chain <= {chain[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on/system reset controller: holds reset, releases NUM_CH domains in a
// staggered order, and re-runs the sequence on software or watchdog requests.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned HOLD_CYCLES = 31,
  parameter int unsigned STAGGER     = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WDT_CYCLES  = 0
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic              sw_rst_req,
  input  logic              wdt_en,
  input  logic              wdt_kick,
  output logic [NUM_CH-1:0] rst_out,
  output logic              ready,
  output logic [1:0]        cause
);

  localparam int unsigned CNT_MAX = HOLD_CYCLES + (NUM_CH - 1) * STAGGER;
  localparam int unsigned CW      = $clog2(CNT_MAX + 2);

  logic [CW-1:0]     cnt;
  logic [1:0]        state;
  logic              sync_out;
  logic              pend;
  logic [1:0]        pend_cause;
  logic              sw_hit;
  logic              wdt_expire;
  logic              trig;
  logic [NUM_CH-1:0] rel_now;

  reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK      (CLK),
    .resetn   (resetn),
    .sync_out (sync_out)
  );

  always_comb begin
    rel_now = '0;
    for (int unsigned k = 0; k < NUM_CH; k++)
      rel_now[k] = sync_out && (cnt == CW'(release_count(HOLD_CYCLES, STAGGER, k)));
  end

  assign sw_hit = (state == ST_RUN) && sw_rst_req;
  assign trig   = sw_hit || wdt_expire;

  // Requests are registered into pend, so the reset lands one edge after the
  // sampling edge; that edge also serves as T0 since the synchroniser stays high.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_ASSERT;
      cnt        <= '0;
      rst_out    <= '1;
      ready      <= 1'b0;
      cause      <= CAUSE_POR;
      pend       <= 1'b0;
      pend_cause <= CAUSE_POR;
    end else if (pend) begin
      state   <= ST_ASSERT;
      cnt     <= '0;
      rst_out <= '1;
      ready   <= 1'b0;
      cause   <= pend_cause;
      pend    <= 1'b0;
    end else begin
      pend       <= trig;
      pend_cause <= sw_hit ? CAUSE_SW : CAUSE_WDT;
      ready      <= (state == ST_RUN);
      if (state != ST_RUN && sync_out) begin
        if (cnt != CW'(CNT_MAX)) cnt <= cnt + 1'b1;
        rst_out <= rst_out & ~rel_now;
        if (rel_now[NUM_CH-1])  state <= ST_RUN;
        else if (rel_now[0])    state <= ST_RELEASE;
      end
    end
  end

  if (WDT_CYCLES > 0) begin : g_wdt
    localparam int unsigned WW = $clog2(WDT_CYCLES + 1);
    logic [WW-1:0] wdt_cnt;

    always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn)
        wdt_cnt <= '0;
      else if (state != ST_RUN || pend || !wdt_en || wdt_kick)
        wdt_cnt <= '0;
      else if (wdt_cnt != WW'(WDT_CYCLES - 1))
        wdt_cnt <= wdt_cnt + 1'b1;
    end

    assign wdt_expire = (state == ST_RUN) && wdt_en && !wdt_kick &&
                        (wdt_cnt == WW'(WDT_CYCLES - 1));
  end else begin : g_no_wdt
    logic wdt_unused;
    assign wdt_unused = wdt_en ^ wdt_kick;
    assign wdt_expire = 1'b0;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised power-on/system reset controller that replaces the fixed 5-bit reset counter at the top level. It synchronises an external asynchronous reset, holds reset for a programmable number of cycles, then releases NUM_CH reset domains one after another with a programmable stagger. It also re-enters the reset sequence on a software request or a watchdog timeout, and records the cause of the last reset for the SoC to read.

Parameters:
NUM_CH, 2, number of reset output channels (>=1); channel 0 is released first.
HOLD_CYCLES, 31, cycles reset is held after the synchronised release (>=1).
STAGGER, 16, cycles between successive channel releases (0 = all channels release together).
SYNC_STAGES, 2, synchroniser depth on resetn deassertion (>=2).
WDT_CYCLES, 0, watchdog timeout in cycles; 0 removes the watchdog logic.

Ports:
CLK  input  1  system clock
resetn  input  1  asynchronous active-low reset; assertion is async, deassertion is synchronised internally
sw_rst_req  input  1  software reset request, sampled on CLK; honoured only in RUN
wdt_en  input  1  watchdog enable (level)
wdt_kick  input  1  watchdog restart pulse
rst_out  output  NUM_CH  active-high reset per domain, feeds the soc reset input
ready  output  1  high while all domains are out of reset
cause  output  2  last reset cause: 0 = power-on/external, 1 = software, 2 = watchdog, 3 = reserved

Behaviour:
- resetn low (async): rst_out = all ones, ready = 0, cause = 0, counters = 0, state = ASSERT, wdt counter = 0, synchroniser cleared.
- Synchroniser: resetn high propagates through SYNC_STAGES flops. T0 = first CLK edge where the synchroniser output is high.
- States: ASSERT -> RELEASE -> RUN. Software and watchdog resets go RUN -> ASSERT. Any resetn low goes to ASSERT.
- ASSERT: the sequence counter starts at 0 at T0 and increments once per cycle.
- Release timing: rst_out[k] goes low on edge T0 + HOLD_CYCLES + k*STAGGER, for k = 0..NUM_CH-1.
- Once released, a channel stays low until the next reset event.
- RUN: entered on the edge where rst_out[NUM_CH-1] goes low. ready rises one cycle after that edge.
- Counter width: clog2(HOLD_CYCLES + (NUM_CH-1)*STAGGER + 2). The counter must never wrap.
- Software reset: sw_rst_req high at an edge in RUN causes the following:
  - At the next edge, rst_out = all ones (synchronous assertion), ready = 0, cause = 1, counter = 0, state = ASSERT.
  - That edge counts as T0; the synchroniser is not re-run.
- sw_rst_req is ignored in ASSERT and RELEASE.
- Watchdog (WDT_CYCLES > 0, RUN only):
  - The counter increments each cycle while wdt_en = 1.
  - The counter clears on wdt_kick, or while wdt_en = 0.
  - When the counter equals WDT_CYCLES-1 with no kick, the next edge starts a reset as for software, but with cause = 2.
- Precedence within one cycle:
  - resetn low beats everything.
  - sw_rst_req beats watchdog expiry (cause = 1).
  - wdt_kick beats expiry (no reset).
- cause holds through software and watchdog sequences. Only resetn returns it to 0.
- resetn assertion mid-sequence aborts immediately to the reset values. A glitch shorter than one cycle still fully restarts the sequence.
- STAGGER = 0: all channels release on edge T0 + HOLD_CYCLES.
- NUM_CH = 1: RELEASE collapses to a single edge.
- No combinational path from any input to any output, except resetn, which is the async clear.

Decomposition:
- Shared package/include reset_pkg holds:
  - cause encodings: CAUSE_POR = 0, CAUSE_SW = 1, CAUSE_WDT = 2
  - state encodings: ST_ASSERT, ST_RELEASE, ST_RUN
- One sub-module, reset_sync: a SYNC_STAGES-deep flop chain with async clear and synchronous release. It is reusable for any other async-reset input.
- The watchdog stays inline and is wrapped in a generate block on WDT_CYCLES > 0.

Test Plan:
- Power-on, defaults: release resetn at cycle 0 -> T0 at cycle 2; rst_out[0] low at edge 33, rst_out[1] low at edge 49, ready high at edge 50, cause = 0.
- Mid-sequence abort: pulse resetn low for 3 ns at cycle 40 -> rst_out = 2'b11 immediately, ready = 0; the full 2+31+16 timing restarts from the new release.
- Software reset in RUN: sw_rst_req for 1 cycle at edge E -> rst_out = 2'b11 at E+1, cause = 1, rst_out[0] low at E+1+31, ready high at E+1+48; a repeated request during ASSERT has no effect.
- Watchdog, WDT_CYCLES = 100: wdt_en = 1 with no kick -> reset after 100 cycles in RUN with cause = 2; kicking every 50 cycles gives no reset; a kick on the expiry cycle gives no reset.
- Simultaneous events: sw_rst_req on the watchdog expiry cycle -> single reset, cause = 1. resetn low afterwards -> cause = 0.
- Parameter sweep: (NUM_CH = 1, STAGGER = 0), (NUM_CH = 4, STAGGER = 0) and (NUM_CH = 4, HOLD_CYCLES = 1, STAGGER = 3) -> release edges equal T0 + HOLD_CYCLES + k*STAGGER exactly; release order is monotonic, with no channel reasserting before the next reset event.
